// File: rtl/pll_reset_sequencer.sv
// pll_reset_sequencer
// Powers up the clock PLL, waits for a stable lock, and holds the system reset
// for the PLL clock domains until the lock has been filtered and a hold time
// has elapsed. Retries on lock timeout and gives up after MAX_RETRIES attempts.
// Runs on the raw board clock, which also feeds the PLL reference input.
//
// state      | meaning
// -----------+---------------------------------------------------------------
// PWRDN      | PLL held powered down for PD_CYCLES
// DIVRST     | PLL powered, output divider held in reset for DIVRST_CYCLES
// WAIT_LOCK  | waiting for synced lock, up to LOCK_TIMEOUT cycles
// FILTER     | lock must stay high for LOCK_FILTER consecutive cycles
// HOLD       | lock good, sys_reset held for RST_HOLD more cycles
// RUN        | clocks usable; two consecutive low lock samples restart
// FAIL       | retries exhausted; PLL parked powered down until reset

module pll_reset_sequencer #(
  parameter int unsigned PD_CYCLES     = 1000,
  parameter int unsigned DIVRST_CYCLES = 16,
  parameter int unsigned LOCK_TIMEOUT  = 50000,
  parameter int unsigned LOCK_FILTER   = 256,
  parameter int unsigned RST_HOLD      = 1024,
  parameter int unsigned MAX_RETRIES   = 7
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pll_lock,
  output logic       pll_powerdown,
  output logic       pll_divrst,
  output logic       sys_reset,
  output logic       clocks_ok,
  output logic       lock_lost,
  output logic       fail,
  output logic [3:0] retry_count
);

  typedef enum logic [2:0] {
    ST_PWRDN     = 3'd0,
    ST_DIVRST    = 3'd1,
    ST_WAIT_LOCK = 3'd2,
    ST_FILTER    = 3'd3,
    ST_HOLD      = 3'd4,
    ST_RUN       = 3'd5,
    ST_FAIL      = 3'd6
  } state_t;

  // Terminal counts: a state of length N exits on the edge where cnt == N-1.
  localparam logic [15:0] PD_LAST      = 16'(PD_CYCLES - 1);
  localparam logic [15:0] DIVRST_LAST  = 16'(DIVRST_CYCLES - 1);
  localparam logic [15:0] TIMEOUT_LAST = 16'(LOCK_TIMEOUT - 1);
  localparam logic [15:0] FILTER_LAST  = 16'(LOCK_FILTER - 1);
  localparam logic [15:0] HOLD_LAST    = 16'(RST_HOLD - 1);
  localparam logic [3:0]  RETRY_LIMIT  = 4'(MAX_RETRIES);

  state_t      state;
  state_t      nxt_state;
  logic [15:0] cnt;
  logic        lock_m;
  logic        lock_s;
  logic        run_drop;
  logic        nxt_run_drop;
  logic [3:0]  nxt_retry;
  logic        nxt_lost;
  logic [3:0]  retry_inc;

  // Two-flop synchroniser; pll_lock is asynchronous to clk.
  always_ff @(posedge clk) begin
    if (reset) begin
      lock_m <= 1'b0;
      lock_s <= 1'b0;
    end else begin
      lock_m <= pll_lock;
      lock_s <= lock_m;
    end
  end

  assign retry_inc = (retry_count == 4'd15) ? 4'd15 : retry_count + 4'd1;

  // Next-state decision and the bookkeeping that rides on each transition.
  always_comb begin
    nxt_state    = state;
    nxt_retry    = retry_count;
    nxt_lost     = lock_lost;
    nxt_run_drop = 1'b0;
    case (state)
      ST_PWRDN: begin
        if (cnt == PD_LAST) nxt_state = ST_DIVRST;
      end
      ST_DIVRST: begin
        if (cnt == DIVRST_LAST) nxt_state = ST_WAIT_LOCK;
      end
      ST_WAIT_LOCK: begin
        // A lock arriving on the timeout cycle wins over the retry.
        if (lock_s) begin
          nxt_state = ST_FILTER;
        end else if (cnt == TIMEOUT_LAST) begin
          nxt_retry = retry_inc;
          nxt_state = (retry_inc == RETRY_LIMIT) ? ST_FAIL : ST_PWRDN;
        end
      end
      ST_FILTER: begin
        // Losing lock on the last filter cycle still sends us back.
        if (!lock_s) nxt_state = ST_WAIT_LOCK;
        else if (cnt == FILTER_LAST) nxt_state = ST_HOLD;
      end
      ST_HOLD: begin
        if (!lock_s) begin
          nxt_state = ST_WAIT_LOCK;
        end else if (cnt == HOLD_LAST) begin
          nxt_state = ST_RUN;
          nxt_retry = 4'd0;
        end
      end
      ST_RUN: begin
        nxt_retry = 4'd0;
        // A single low sample is tolerated; the second in a row restarts.
        if (!lock_s) begin
          if (run_drop) begin
            nxt_state = ST_PWRDN;
            nxt_lost  = 1'b1;
          end else begin
            nxt_run_drop = 1'b1;
          end
        end
      end
      ST_FAIL: begin
        nxt_state = ST_FAIL;
      end
      default: begin
        nxt_state = ST_PWRDN;
      end
    endcase
  end

  // State, shared counter and outputs, all decoded from the next state so
  // they change on the same edge as the state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= ST_PWRDN;
      cnt           <= 16'd0;
      run_drop      <= 1'b0;
      retry_count   <= 4'd0;
      lock_lost     <= 1'b0;
      pll_powerdown <= 1'b0;
      pll_divrst    <= 1'b1;
      sys_reset     <= 1'b1;
      clocks_ok     <= 1'b0;
      fail          <= 1'b0;
    end else begin
      state       <= nxt_state;
      run_drop    <= nxt_run_drop;
      retry_count <= nxt_retry;
      lock_lost   <= nxt_lost;
      if (nxt_state != state) begin
        cnt <= 16'd0;
      end else if (cnt != 16'hFFFF) begin
        cnt <= cnt + 16'd1;
      end
      pll_powerdown <= !((nxt_state == ST_PWRDN) || (nxt_state == ST_FAIL));
      pll_divrst    <= (nxt_state == ST_PWRDN) || (nxt_state == ST_DIVRST) ||
                       (nxt_state == ST_FAIL);
      sys_reset     <= (nxt_state != ST_RUN);
      clocks_ok     <= (nxt_state == ST_RUN);
      fail          <= (nxt_state == ST_FAIL);
    end
  end

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed bench for pll_reset_sequencer with shortened cycle parameters.
// Edge numbers count rising edges after the reset edge (edge 1 is the first
// edge with reset low). Inputs change and outputs are sampled 1 time unit
// after a rising edge.

module tb_pll_reset_sequencer;

  logic       clk;
  logic       reset;
  logic       pll_lock;
  logic       pll_powerdown;
  logic       pll_divrst;
  logic       sys_reset;
  logic       clocks_ok;
  logic       lock_lost;
  logic       fail;
  logic [3:0] retry_count;

  int checks = 0;
  int errors = 0;
  int edge_n = 0;

  pll_reset_sequencer #(
    .PD_CYCLES    (8),
    .DIVRST_CYCLES(4),
    .LOCK_TIMEOUT (100),
    .LOCK_FILTER  (16),
    .RST_HOLD     (32),
    .MAX_RETRIES  (3)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .pll_lock     (pll_lock),
    .pll_powerdown(pll_powerdown),
    .pll_divrst   (pll_divrst),
    .sys_reset    (sys_reset),
    .clocks_ok    (clocks_ok),
    .lock_lost    (lock_lost),
    .fail         (fail),
    .retry_count  (retry_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         adv;
    logic       rst;
    logic       lock;
    logic [9:0] exp;
    string      name;
  } vec_t;

  vec_t vq[$];

  // {pd, divrst, sys_reset, clocks_ok, lock_lost, fail, retry_count}
  function automatic logic [9:0] mk(input logic pd, input logic dv, input logic sr,
                                    input logic ok, input logic ll, input logic fl,
                                    input logic [3:0] rc);
    return {pd, dv, sr, ok, ll, fl, rc};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    edge_n++;
  endtask

  task automatic go_to(input int e);
    while (edge_n < e) tick();
  endtask

  task automatic chk(input string nm, input logic [9:0] exp);
    logic [9:0] act;
    act = {pll_powerdown, pll_divrst, sys_reset, clocks_ok, lock_lost, fail, retry_count};
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @edge %0d: got pd/div/sr/ok/lost/fail/rc=%b expected %b",
               nm, edge_n, act, exp);
    end
  endtask

  task automatic do_reset(input logic lock_val);
    reset    = 1'b1;
    pll_lock = lock_val;
    @(posedge clk);
    #1;
    reset  = 1'b0;
    edge_n = 0;
    chk("reset_values", mk(0, 1, 1, 0, 0, 0, 4'd0));
  endtask

  initial begin
    logic [9:0] rv;
    reset    = 1'b1;
    pll_lock = 1'b0;
    rv = mk(0, 1, 1, 0, 0, 0, 4'd0);

    // Cold start with lock tied high.
    vq.push_back('{1,    1'b1, 1'b1, rv,                        "s1_reset"});
    vq.push_back('{7,    1'b0, 1'b1, mk(0,1,1,0,0,0,4'd0),      "s1_pwrdn_e7"});
    vq.push_back('{1,    1'b0, 1'b1, mk(1,1,1,0,0,0,4'd0),      "s1_divrst_e8"});
    vq.push_back('{3,    1'b0, 1'b1, mk(1,1,1,0,0,0,4'd0),      "s1_divrst_e11"});
    vq.push_back('{1,    1'b0, 1'b1, mk(1,0,1,0,0,0,4'd0),      "s1_wait_e12"});
    vq.push_back('{48,   1'b0, 1'b1, mk(1,0,1,0,0,0,4'd0),      "s1_hold_e60"});
    vq.push_back('{1,    1'b0, 1'b1, mk(1,0,0,1,0,0,4'd0),      "s1_run_e61"});
    // Lock never arrives: three 112-cycle attempts then FAIL.
    vq.push_back('{1,    1'b1, 1'b0, rv,                        "s2_reset"});
    vq.push_back('{111,  1'b0, 1'b0, mk(1,0,1,0,0,0,4'd0),      "s2_wait_e111"});
    vq.push_back('{1,    1'b0, 1'b0, mk(0,1,1,0,0,0,4'd1),      "s2_retry1_e112"});
    vq.push_back('{111,  1'b0, 1'b0, mk(1,0,1,0,0,0,4'd1),      "s2_wait_e223"});
    vq.push_back('{1,    1'b0, 1'b0, mk(0,1,1,0,0,0,4'd2),      "s2_retry2_e224"});
    vq.push_back('{111,  1'b0, 1'b0, mk(1,0,1,0,0,0,4'd2),      "s2_wait_e335"});
    vq.push_back('{1,    1'b0, 1'b0, mk(0,1,1,0,0,1,4'd3),      "s2_fail_e336"});
    vq.push_back('{1200, 1'b0, 1'b0, mk(0,1,1,0,0,1,4'd3),      "s2_fail_held"});
    // Reset out of FAIL, then reset mid-HOLD at hold count 20.
    vq.push_back('{1,    1'b1, 1'b1, rv,                        "s5_reset_in_fail"});
    vq.push_back('{7,    1'b0, 1'b1, mk(0,1,1,0,0,0,4'd0),      "s5_pwrdn_e7"});
    vq.push_back('{1,    1'b0, 1'b1, mk(1,1,1,0,0,0,4'd0),      "s5_divrst_e8"});
    vq.push_back('{41,   1'b0, 1'b1, mk(1,0,1,0,0,0,4'd0),      "s5_hold_cnt20"});
    vq.push_back('{1,    1'b1, 1'b1, rv,                        "s5_reset_in_hold"});
    vq.push_back('{7,    1'b0, 1'b1, mk(0,1,1,0,0,0,4'd0),      "s5_restart_e7"});
    vq.push_back('{1,    1'b0, 1'b1, mk(1,1,1,0,0,0,4'd0),      "s5_restart_e8"});
    vq.push_back('{53,   1'b0, 1'b1, mk(1,0,0,1,0,0,4'd0),      "s5_run_e61"});

    for (int i = 0; i < vq.size(); i++) begin
      reset    = vq[i].rst;
      pll_lock = vq[i].lock;
      for (int k = 0; k < vq[i].adv; k++) tick();
      chk(vq[i].name, vq[i].exp);
    end

    // Scenario 3: lock_s low for one cycle at filter count 10.
    do_reset(1'b0);
    go_to(19);  pll_lock = 1'b1;
    go_to(30);  pll_lock = 1'b0;
    go_to(31);  pll_lock = 1'b1;
    go_to(70);  chk("s3_no_run_at_70", mk(1,0,1,0,0,0,4'd0));
    go_to(81);  chk("s3_hold_e81",     mk(1,0,1,0,0,0,4'd0));
    go_to(82);  chk("s3_run_e82",      mk(1,0,0,1,0,0,4'd0));

    // Scenario 4: glitch ignored in RUN, two-cycle drop restarts.
    do_reset(1'b1);
    go_to(61);  chk("s4_run_e61",        mk(1,0,0,1,0,0,4'd0));
    go_to(70);  pll_lock = 1'b0;
    go_to(71);  pll_lock = 1'b1;
    go_to(73);  chk("s4_glitch_e73",     mk(1,0,0,1,0,0,4'd0));
    go_to(80);  chk("s4_glitch_ignored", mk(1,0,0,1,0,0,4'd0));
    go_to(90);  pll_lock = 1'b0;
    go_to(92);  pll_lock = 1'b1;
    go_to(93);  chk("s4_drop_e3",        mk(1,0,0,1,0,0,4'd0));
    go_to(94);  chk("s4_lost_e4",        mk(0,1,1,0,1,0,4'd0));
    go_to(154); chk("s4_relock_hold",    mk(1,0,1,0,1,0,4'd0));
    go_to(155); chk("s4_relock_run",     mk(1,0,0,1,1,0,4'd0));

    // Scenario 6: lock arrives exactly on the timeout cycle of attempt 2.
    do_reset(1'b0);
    go_to(112); chk("s6_first_timeout", mk(0,1,1,0,0,0,4'd1));
    go_to(221); pll_lock = 1'b1;
    go_to(224); chk("s6_lock_wins",     mk(1,0,1,0,0,0,4'd1));
    go_to(271); chk("s6_hold_e271",     mk(1,0,1,0,0,0,4'd1));
    go_to(272); chk("s6_run_clears_rc", mk(1,0,0,1,0,0,4'd0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
